pwm_duty_sequencer: RTL and testbench

- Controller that owns the duty-cycle value driven into the PWM datapath. The PWM datapath has a 4-bit period counter and compares it against duty.
- Arbitrates duty requests from two sources: debounced inc/dec button pulses and a host load interface with a req/ack handshake.
- Ramps the applied duty toward the requested target one step at a time, and only at PWM period boundaries, so the output never shows a torn period.
- Provides soft-start and soft-stop through an enable input.

---
 rtl/pwm_duty_sequencer_if.sv | 12 +
 rtl/pwm_duty_sequencer.sv | 133 +++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_sequencer_if.sv
// Host duty-load handshake between a host controller and pwm_duty_sequencer.
// The host holds host_req until it sees a one-cycle host_ack.
interface pwm_duty_sequencer_if #(
  parameter int DUTY_W = 4
);
  logic              host_req;
  logic [DUTY_W-1:0] host_duty;
  logic              host_ack;

  modport master (output host_req, output host_duty, input host_ack);
  modport slave  (input host_req, input host_duty, output host_ack);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Owns the PWM duty value: arbitrates host/button requests into a target and
// ramps duty_out toward it one count per RAMP_DIV periods, with soft-stop/start.
module pwm_duty_sequencer #(
  parameter int DUTY_W       = 4,
  parameter int DUTY_MAX     = 10,
  parameter int DEFAULT_DUTY = 5,
  parameter int RAMP_DIV     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                period_end,
  input  logic                enable,
  input  logic                btn_inc,
  input  logic                btn_dec,
  pwm_duty_sequencer_if.slave host,
  output logic [DUTY_W-1:0]   duty_out,
  output logic                duty_load,
  output logic                busy,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DUTY_DEF_V = DUTY_W'(DEFAULT_DUTY);
  localparam logic [3:0]        CNT_LAST   = 4'(RAMP_DIV - 1);

  state_t            state_reg;
  logic [DUTY_W-1:0] target_reg;
  logic [DUTY_W-1:0] target_next;
  logic [DUTY_W-1:0] duty_step;
  logic [3:0]        cnt_reg;
  logic              off_pending_reg;
  logic              accept;

  // Host wins over buttons; buttons pressed together cancel out.
  always_comb begin
    accept      = host.host_req && !host.host_ack;
    target_next = target_reg;
    if (accept) begin
      target_next = (host.host_duty > DUTY_MAX_V) ? DUTY_MAX_V : host.host_duty;
    end else if (btn_inc && !btn_dec) begin
      if (target_reg < DUTY_MAX_V) target_next = target_reg + DUTY_W'(1);
    end else if (btn_dec && !btn_inc) begin
      if (target_reg != '0) target_next = target_reg - DUTY_W'(1);
    end
  end

  // Direction is taken fresh from the current target, so a reversed target never overshoots.
  assign duty_step = (target_reg > duty_out) ? duty_out + DUTY_W'(1) : duty_out - DUTY_W'(1);
  assign state     = state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      target_reg      <= DUTY_DEF_V;
      duty_out        <= DUTY_DEF_V;
      state_reg       <= IDLE;
      busy            <= 1'b0;
      cnt_reg         <= '0;
      off_pending_reg <= 1'b0;
      host.host_ack   <= 1'b0;
      duty_load       <= 1'b0;
    end else begin
      target_reg    <= target_next;
      host.host_ack <= accept;
      duty_load     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!enable) begin
            state_reg       <= OFF;
            busy            <= 1'b1;
            off_pending_reg <= 1'b1;
          end else if (target_reg != duty_out) begin
            state_reg <= RAMP;
            busy      <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        RAMP: begin
          if (!enable) begin
            state_reg       <= OFF;
            busy            <= 1'b1;
            off_pending_reg <= 1'b1;
          end else if (target_reg == duty_out) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (period_end) begin
            if (cnt_reg == CNT_LAST) begin
              cnt_reg   <= '0;
              duty_out  <= duty_step;
              duty_load <= 1'b1;
              if (duty_step == target_reg) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        OFF: begin
          // Hard stop on the first period boundary after entry, then hold 0.
          if (period_end && off_pending_reg) begin
            off_pending_reg <= 1'b0;
            if (duty_out != '0) begin
              duty_out  <= '0;
              duty_load <= 1'b1;
            end
          end
          if (enable) begin
            cnt_reg <= '0;
            if (target_reg == '0) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg <= RAMP;
              busy      <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench: a period-level reference model predicts state, duty and pulses
// per edge; a negedge monitor pops and compares. Directed phases then random traffic.
module tb_pwm_duty_sequencer;
  localparam int DW = 4, DMAX = 10, DDEF = 5, RDIV = 2;
  localparam int S_IDLE = 0, S_RAMP = 1, S_OFF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, period_end = 1'b0, enable = 1'b1, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [DW-1:0] duty_out;
  logic          duty_load, busy;
  logic [1:0]    state;

  pwm_duty_sequencer_if #(.DUTY_W(DW)) hif();

  pwm_duty_sequencer #(.DUTY_W(DW), .DUTY_MAX(DMAX), .DEFAULT_DUTY(DDEF), .RAMP_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .period_end(period_end), .enable(enable),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .host(hif),
    .duty_out(duty_out), .duty_load(duty_load), .busy(busy), .state(state)
  );

  typedef struct { int st; int duty; } exp_t;
  exp_t exp_q[$];
  int   load_q[$];
  int   ack_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b1;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int pwm_cnt = 0, n_pe = 0, n_loads = 0;
  bit seen_hi = 1'b0;

  // Reference model state: what the controller should hold after the last edge.
  int m_target, m_duty, m_mode, m_periods;
  bit m_ack = 1'b0, m_arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void bound_fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endfunction

  // Predicts the result of the coming clock edge from the inputs about to be sampled.
  function automatic void model_edge(bit r, bit pe, bit en, bit inc, bit dec, bit hreq, int hduty);
    int t0, d0;
    bit acc;
    if (r) begin
      m_target = DDEF; m_duty = DDEF; m_mode = S_IDLE;
      m_periods = 0; m_ack = 1'b0; m_arm = 1'b0;
    end else begin
      t0  = m_target;
      d0  = m_duty;
      acc = hreq && !m_ack;
      if (acc) begin
        m_target = (hduty > DMAX) ? DMAX : hduty;
        ack_q.push_back(cyc + 1);
      end else if (inc && !dec) begin
        m_target = (t0 < DMAX) ? t0 + 1 : DMAX;
      end else if (dec && !inc) begin
        m_target = (t0 > 0) ? t0 - 1 : 0;
      end
      m_ack = acc;
      if (m_mode != S_OFF && !en) begin
        m_mode = S_OFF;
        m_arm  = 1'b1;
      end else if (m_mode == S_IDLE) begin
        if (t0 != d0) begin m_mode = S_RAMP; m_periods = 0; end
      end else if (m_mode == S_RAMP) begin
        if (t0 == d0) begin
          m_mode = S_IDLE;
        end else if (pe) begin
          m_periods++;
          if (m_periods % RDIV == 0) begin
            m_duty = d0 + ((t0 > d0) ? 1 : -1);
            load_q.push_back(cyc + 1);
            if (m_duty == t0) m_mode = S_IDLE;
          end
        end
      end else begin
        if (pe && m_arm) begin
          m_arm = 1'b0;
          if (d0 != 0) begin m_duty = 0; load_q.push_back(cyc + 1); end
        end
        if (en) begin
          m_periods = 0;
          m_mode = (t0 == 0) ? S_IDLE : S_RAMP;
        end
      end
    end
    exp_q.push_back('{m_mode, m_duty});
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        bound_fail("expect_queue_empty");
      end else begin
        mon_e = exp_q.pop_front();
        chk("state", int'(state), mon_e.st);
        chk("busy", int'(busy), int'(mon_e.st != S_IDLE));
        chk("duty_out", int'(duty_out), mon_e.duty);
      end
      if (load_q.size() > 0 && load_q[0] == cyc) begin
        chk("duty_load", int'(duty_load), 1);
        void'(load_q.pop_front());
      end else begin
        chk("duty_load", int'(duty_load), 0);
      end
      if (ack_q.size() > 0 && ack_q[0] == cyc) begin
        chk("host_ack", int'(hif.host_ack), 1);
        void'(ack_q.pop_front());
      end else begin
        chk("host_ack", int'(hif.host_ack), 0);
      end
    end
  end

  task automatic drive_cycle();
    period_end = (pwm_cnt == 9);
    model_edge(rst, period_end, enable, btn_inc, btn_dec, hif.host_req, int'(hif.host_duty));
    pwm_cnt = (pwm_cnt + 1) % 10;
    if (period_end) n_pe++;
    @(posedge clk);
    #1;
    rst = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    if (duty_load) n_loads++;
    if (duty_out >= 4'd8) seen_hi = 1'b1;
  endtask

  task automatic run(int n);
    repeat (n) drive_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_cycle();
    rst = 1'b1; drive_cycle();
  endtask

  task automatic host_load(int v, bit with_dec);
    int k = 0;
    hif.host_req = 1'b1; hif.host_duty = DW'(v); btn_dec = with_dec;
    do begin drive_cycle(); k++; end while (!m_ack && k < 8);
    hif.host_req = 1'b0;
    if (!m_ack) bound_fail("host_load");
  endtask

  task automatic settle(int budget, string name);
    int k = 0;
    while (!(m_mode == S_IDLE && m_target == m_duty) && k < budget) begin drive_cycle(); k++; end
    if (!(m_mode == S_IDLE && m_target == m_duty)) bound_fail(name);
  endtask

  initial begin
    int l0, p0, k;
    hif.host_req = 1'b0; hif.host_duty = '0;

    // Idle after reset: three periods, nothing moves.
    do_reset();
    l0 = n_loads; p0 = n_pe; k = 0;
    while (n_pe - p0 < 3 && k < 40) begin drive_cycle(); k++; end
    chk("p1_duty", int'(duty_out), 5);
    chk("p1_state", int'(state), S_IDLE);
    chk("p1_loads", n_loads - l0, 0);

    // Six inc presses saturate at DUTY_MAX.
    l0 = n_loads;
    for (int i = 0; i < 6; i++) begin btn_inc = 1'b1; drive_cycle(); drive_cycle(); end
    settle(400, "p2_settle");
    chk("p2_duty", int'(duty_out), 10);
    chk("p2_state", int'(state), S_IDLE);
    chk("p2_busy", int'(busy), 0);
    chk("p2_loads", n_loads - l0, 5);

    // Host load 14 with a simultaneous dec: clamped to 10, dec dropped.
    do_reset();
    l0 = n_loads;
    host_load(14, 1'b1);
    chk("p3_ack", int'(hif.host_ack), 1);
    settle(400, "p3_settle");
    chk("p3_duty", int'(duty_out), 10);
    chk("p3_loads", n_loads - l0, 5);

    // Reversal mid-ramp at 7 toward 10, new target 6.
    do_reset();
    host_load(10, 1'b0);
    k = 0;
    while (m_duty != 7 && k < 200) begin drive_cycle(); k++; end
    if (m_duty != 7) bound_fail("p4_reach7");
    chk("p4_at7", int'(duty_out), 7);
    seen_hi = 1'b0; l0 = n_loads;
    host_load(6, 1'b0);
    settle(200, "p4_settle");
    chk("p4_duty", int'(duty_out), 6);
    chk("p4_state", int'(state), S_IDLE);
    chk("p4_no_overshoot", int'(seen_hi), 0);
    chk("p4_loads", n_loads - l0, 1);

    // Soft-stop at 8, then soft-start back to 8.
    host_load(8, 1'b0);
    settle(200, "p5_settle_up");
    chk("p5_duty8", int'(duty_out), 8);
    enable = 1'b0; l0 = n_loads;
    run(12);
    chk("p5_off_duty", int'(duty_out), 0);
    chk("p5_off_state", int'(state), S_OFF);
    chk("p5_off_busy", int'(busy), 1);
    chk("p5_off_loads", n_loads - l0, 1);
    enable = 1'b1; l0 = n_loads;
    settle(400, "p5_settle_start");
    chk("p5_on_duty", int'(duty_out), 8);
    chk("p5_on_state", int'(state), S_IDLE);
    chk("p5_on_loads", n_loads - l0, 8);

    // Simultaneous buttons cancel; reset abandons a ramp.
    btn_inc = 1'b1; btn_dec = 1'b1; drive_cycle();
    run(30);
    chk("p6_duty", int'(duty_out), 8);
    chk("p6_state", int'(state), S_IDLE);
    host_load(2, 1'b0);
    run(25);
    chk("p6_ramping", int'(state), S_RAMP);
    rst = 1'b1; drive_cycle();
    chk("p6_rst_duty", int'(duty_out), 5);
    chk("p6_rst_state", int'(state), S_IDLE);
    chk("p6_rst_ack", int'(hif.host_ack), 0);
    chk("p6_rst_load", int'(duty_load), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) rst = 1'b1;
      if ($urandom_range(149) == 0) enable = ~enable;
      k = $urandom_range(19);
      if (k == 0) btn_inc = 1'b1;
      if (k == 1) btn_dec = 1'b1;
      if (k == 2) begin btn_inc = 1'b1; btn_dec = 1'b1; end
      if (hif.host_req) begin
        if (m_ack) begin
          if ($urandom_range(3) == 0) hif.host_duty = DW'($urandom_range(15));
          else hif.host_req = 1'b0;
        end
      end else if ($urandom_range(29) == 0) begin
        hif.host_req = 1'b1;
        hif.host_duty = DW'($urandom_range(15));
      end
      drive_cycle();
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("load_q_drained", load_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
